// File: rtl/counter_tc_pkg.sv
// Shared opcode and direction definitions for the counter_tc word/frame counter.
package counter_tc_pkg;

  typedef enum logic [1:0] {
    OPC_HOLD = 2'b00,
    OPC_STEP = 2'b01,
    OPC_CLR  = 2'b10,
    OPC_LD   = 2'b11
  } opc_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/counter_tc_if.sv
// Control/status bundle between a sequencing FSM (master) and counter_tc (slave).
interface counter_tc_if #(
  parameter int Width    = 5,
  parameter int FrmWidth = 1
);
  logic [1:0]          opc_i;
  logic                dir_i;
  logic [Width-1:0]    tc_i;
  logic [Width-1:0]    ld_i;
  logic [Width-1:0]    cnt_o;
  logic                flag_o;
  logic                done_o;
  logic [FrmWidth-1:0] frm_cnt_o;
  logic                frm_done_o;

  modport master (
    output opc_i, dir_i, tc_i, ld_i,
    input  cnt_o, flag_o, done_o, frm_cnt_o, frm_done_o
  );

  modport slave (
    input  opc_i, dir_i, tc_i, ld_i,
    output cnt_o, flag_o, done_o, frm_cnt_o, frm_done_o
  );
endinterface

// File: rtl/counter_tc_step.sv
// Word counter: register with next-state mux and target compare.
module counter_step
  import counter_tc_pkg::*;
#(
  parameter int Width = 5,
  parameter bit Wrap  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  opc_e             opc_i,
  input  logic             dir_i,
  input  logic [Width-1:0] tc_i,
  input  logic [Width-1:0] ld_i,
  output logic [Width-1:0] cnt_o,
  output logic             reached_o,
  output logic             done_o,
  output logic             hit_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [Width-1:0] target;

  always_comb begin
    target    = (dir_i == DIR_DN) ? '0 : tc_i;
    reached_o = (cnt_q == target);
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    case (opc_i)
      OPC_STEP: begin
        if (!reached_o) begin
          cnt_d  = (dir_i == DIR_DN) ? cnt_q - One : cnt_q + One;
          done_d = (cnt_d == target);
        end else if (Wrap) begin
          // Reload step after reaching target never pulses done.
          cnt_d = (dir_i == DIR_DN) ? tc_i : '0;
        end
      end
      OPC_CLR: cnt_d = '0;
      OPC_LD:  cnt_d = ld_i;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = done_q;
  assign hit_o  = done_d;

endmodule

// File: rtl/counter_tc.sv
// Programmable terminal-count word counter with a modulo-Frames completed-word counter.
module counter_tc
  import counter_tc_pkg::*;
#(
  parameter int Width    = 5,
  parameter int Frames   = 1,
  parameter int FrmWidth = $clog2(Frames + 1),
  parameter bit Wrap     = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  counter_tc_if.slave  bus
);

  localparam logic [FrmWidth-1:0] FrmLast = FrmWidth'(Frames - 1);
  localparam logic [FrmWidth-1:0] FrmOne  = FrmWidth'(1);

  opc_e opc;
  logic hit;

  logic [FrmWidth-1:0] frm_cnt_q, frm_cnt_d;
  logic                frm_done_q, frm_done_d;

  assign opc = opc_e'(bus.opc_i);

  counter_step #(
    .Width (Width),
    .Wrap  (Wrap)
  ) u_step (
    .clk_i     (clk_i),
    .rst_ni    (rst_i),
    .opc_i     (opc),
    .dir_i     (bus.dir_i),
    .tc_i      (bus.tc_i),
    .ld_i      (bus.ld_i),
    .cnt_o     (bus.cnt_o),
    .reached_o (bus.flag_o),
    .done_o    (bus.done_o),
    .hit_o     (hit)
  );

  // Frame stage advances on the same edge that registers done_o.
  always_comb begin
    frm_cnt_d  = frm_cnt_q;
    frm_done_d = 1'b0;
    if (opc == OPC_CLR) begin
      frm_cnt_d = '0;
    end else if (hit) begin
      if (frm_cnt_q == FrmLast) begin
        frm_cnt_d  = '0;
        frm_done_d = 1'b1;
      end else begin
        frm_cnt_d = frm_cnt_q + FrmOne;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      frm_cnt_q  <= '0;
      frm_done_q <= 1'b0;
    end else begin
      frm_cnt_q  <= frm_cnt_d;
      frm_done_q <= frm_done_d;
    end
  end

  assign bus.frm_cnt_o  = frm_cnt_q;
  assign bus.frm_done_o = frm_done_q;

endmodule
